// File: rtl/simple_ff_async.sv
// simple_ff_async: single-bit D flip-flop with clock enable and an
// active-high clear (SR). ASYNC selects between a clear-pin register
// ("TRUE") and a synchronous-clear register ("FALSE").
//
// Priority is SR, then CE, then hold. Q comes straight from the register,
// so there is no combinational path from D to Q. Reset release is not
// synchronised here: in the asynchronous build the integrator deasserts
// SR synchronously to CK.
module simple_ff_async #(
  parameter string ASYNC = "TRUE"
) (
  input  logic CK,
  input  logic SR,
  input  logic CE,
  input  logic D,
  output logic Q
);

  if (ASYNC == "TRUE") begin : g_async
    // Clear-pin register: SR clears Q immediately, with no clock edge needed.
    always_ff @(posedge CK or posedge SR) begin
      if (SR) begin
        Q <= 1'b0;
      end else if (CE) begin
        Q <= D;
      end
    end
  end else if (ASYNC == "FALSE") begin : g_sync
    // Synchronous-clear register: SR matters only when sampled at a rising CK edge.
    always_ff @(posedge CK) begin
      if (SR) begin
        Q <= 1'b0;
      end else if (CE) begin
        Q <= D;
      end
    end
  end else begin : g_illegal
    // Any other reset-style string is rejected at elaboration.
    $error("simple_ff_async: ASYNC must be \"TRUE\" or \"FALSE\", got \"%s\"", ASYNC);
    assign Q = 1'b0;
  end

endmodule

// File: tb/tb_simple_ff_async.sv
// Directed bench for simple_ff_async: the asynchronous-clear build and the
// synchronous-clear build share every input, and each output is checked
// against hand-computed values.
module tb_simple_ff_async;

  logic CK;
  logic SR;
  logic CE;
  logic D;
  logic q_a;
  logic q_s;
  logic clk_run;

  int vectors;
  int miscompares;

  simple_ff_async #(.ASYNC("TRUE")) u_async (
    .CK(CK),
    .SR(SR),
    .CE(CE),
    .D (D),
    .Q (q_a)
  );

  simple_ff_async #(.ASYNC("FALSE")) u_sync (
    .CK(CK),
    .SR(SR),
    .CE(CE),
    .D (D),
    .Q (q_s)
  );

  // Clock is held low until the stimulus starts it (10 ns period).
  initial begin
    CK = 1'b0;
    wait (clk_run);
    forever #5 CK = ~CK;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clk_run     = 1'b0;
    SR = 1'b0;
    CE = 1'b0;
    D  = 1'b0;

    // Reset before any clock edge: async build clears at once.
    #100;
    SR = 1'b1;
    #1;
    check("rst_before_clk_async", q_a, 1'b0);

    // Clock starts at about 1100 ns; first edge still sees SR=1.
    #999;
    clk_run = 1'b1;
    tick();
    check("first_edge_async", q_a, 1'b0);
    check("first_edge_sync", q_s, 1'b0);

    // CE gating: SR released, CE=0, then a one-cycle D pulse after five edges.
    SR = 1'b0;
    CE = 1'b0;
    D  = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("ce_low_idle_async", q_a, 1'b0);
    check("ce_low_idle_sync", q_s, 1'b0);
    D = 1'b1;
    tick();
    check("ce_low_dpulse_async", q_a, 1'b0);
    check("ce_low_dpulse_sync", q_s, 1'b0);
    D = 1'b0;
    tick();
    check("ce_low_after_async", q_a, 1'b0);
    check("ce_low_after_sync", q_s, 1'b0);

    // Enabled capture: one-edge latency from D to Q.
    CE = 1'b1;
    D  = 1'b1;
    tick();
    check("capture1_async", q_a, 1'b1);
    check("capture1_sync", q_s, 1'b1);
    D = 1'b0;
    tick();
    check("capture0_async", q_a, 1'b0);
    check("capture0_sync", q_s, 1'b0);
    D = 1'b1;
    tick();
    check("recapture1_async", q_a, 1'b1);
    check("recapture1_sync", q_s, 1'b1);

    // Hold with Q=1: CE=0 ignores D=0 and a D pulse.
    CE = 1'b0;
    D  = 1'b0;
    tick();
    check("hold1_async", q_a, 1'b1);
    check("hold1_sync", q_s, 1'b1);
    #2 D = 1'b1;
    #2 D = 1'b0;
    tick();
    check("hold1_dpulse_async", q_a, 1'b1);
    check("hold1_dpulse_sync", q_s, 1'b1);

    // Reset priority: SR mid-cycle with CE=1, D=1 and Q=1.
    CE = 1'b1;
    D  = 1'b1;
    #3;
    SR = 1'b1;
    #1;
    check("sr_midcycle_async", q_a, 1'b0);
    check("sr_midcycle_sync_waits", q_s, 1'b1);
    tick();
    check("sr_edge_async", q_a, 1'b0);
    check("sr_edge_sync", q_s, 1'b0);
    tick();
    check("sr_held_async", q_a, 1'b0);
    check("sr_held_sync", q_s, 1'b0);

    // Release: first edge with SR=0 and CE=1 loads D.
    SR = 1'b0;
    tick();
    check("release_load_async", q_a, 1'b1);
    check("release_load_sync", q_s, 1'b1);

    // Mid-cycle SR pulse not spanning an edge: only the async build clears.
    #3;
    SR = 1'b1;
    #2;
    SR = 1'b0;
    #1;
    check("glitch_async", q_a, 1'b0);
    check("glitch_sync", q_s, 1'b1);
    tick();
    check("post_glitch_async", q_a, 1'b1);
    check("post_glitch_sync", q_s, 1'b1);

    // SR clears regardless of CE=0.
    CE = 1'b0;
    #3;
    SR = 1'b1;
    #1;
    check("sr_ce0_mid_async", q_a, 1'b0);
    check("sr_ce0_mid_sync", q_s, 1'b1);
    tick();
    check("sr_ce0_edge_sync", q_s, 1'b0);

    // Release with CE=0: Q stays 0 until enabled.
    SR = 1'b0;
    D  = 1'b1;
    tick();
    check("release_ce0_async", q_a, 1'b0);
    check("release_ce0_sync", q_s, 1'b0);
    CE = 1'b1;
    tick();
    check("enable_after_release_async", q_a, 1'b1);
    check("enable_after_release_sync", q_s, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
